// File: rtl/jtframe_vidtimer.sv
// Programmable raster timing generator: pixel/line counters plus HB/VB/HS/VS,
// frame toggle and line_start, all registered and aligned to the counters.
module jtframe_vidtimer #(
  parameter int unsigned HCNT_W   = 9,
  parameter int unsigned VCNT_W   = 9,
  parameter int unsigned H_TOTAL  = 384,
  parameter int unsigned HB_START = 288,
  parameter int unsigned HB_END   = 32,
  parameter int unsigned HS_START = 304,
  parameter int unsigned HS_END   = 336,
  parameter int unsigned V_ADV    = 288,
  parameter int unsigned V_TOTAL  = 264,
  parameter int unsigned VB_START = 224,
  parameter int unsigned VB_END   = 16,
  parameter int unsigned VS_START = 240,
  parameter int unsigned VS_END   = 244
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  output logic [HCNT_W-1:0] hdump,
  output logic [VCNT_W-1:0] vdump,
  output logic              HB,
  output logic              VB,
  output logic              HS,
  output logic              VS,
  output logic              frame,
  output logic              line_start
);

  // Region membership; start>end wraps through zero, start==end is empty.
  function automatic logic in_region(input int unsigned n, input int unsigned s,
                                     input int unsigned e);
    if (s < e)      in_region = (n >= s) && (n < e);
    else if (s > e) in_region = (n >= s) || (n < e);
    else            in_region = 1'b0;
  endfunction

  localparam logic HB_RST = in_region(32'd0, HB_START, HB_END);
  localparam logic HS_RST = in_region(32'd0, HS_START, HS_END);
  localparam logic VB_RST = in_region(32'd0, VB_START, VB_END);
  localparam logic VS_RST = in_region(32'd0, VS_START, VS_END);

  localparam bit PARAMS_OK =
    (H_TOTAL <= (32'd1 << HCNT_W)) && (V_TOTAL <= (32'd1 << VCNT_W)) &&
    (HB_START < H_TOTAL) && (HB_END < H_TOTAL) &&
    (HS_START < H_TOTAL) && (HS_END < H_TOTAL) && (V_ADV < H_TOTAL) &&
    (VB_START < V_TOTAL) && (VB_END < V_TOTAL) &&
    (VS_START < V_TOTAL) && (VS_END < V_TOTAL);

  if (!PARAMS_OK) begin : g_bad_params
    $error("jtframe_vidtimer: totals exceed counter width or a region/V_ADV value is out of range");
  end

  logic [HCNT_W-1:0] hdump_q, hdump_d;
  logic [VCNT_W-1:0] vdump_q, vdump_d;
  logic              hb_q, hb_d, vb_q, vb_d, hs_q, hs_d, vs_q, vs_d;
  logic              frame_q, frame_d, line_start_q, line_start_d;
  logic [HCNT_W-1:0] h_nxt;
  logic [VCNT_W-1:0] v_nxt;
  logic              v_adv;

  // Next-count and decode; strobes decode the value the counters are about to take.
  always_comb begin
    hdump_d      = hdump_q;
    vdump_d      = vdump_q;
    hb_d         = hb_q;
    vb_d         = vb_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    frame_d      = frame_q;
    line_start_d = 1'b0;

    h_nxt = (hdump_q == HCNT_W'(H_TOTAL - 1)) ? '0 : hdump_q + HCNT_W'(1);
    v_adv = (h_nxt == HCNT_W'(V_ADV));
    v_nxt = vdump_q;
    if (v_adv) begin
      v_nxt = (vdump_q == VCNT_W'(V_TOTAL - 1)) ? '0 : vdump_q + VCNT_W'(1);
    end

    if (pxl_cen) begin
      hdump_d      = h_nxt;
      vdump_d      = v_nxt;
      hb_d         = in_region(32'(h_nxt), HB_START, HB_END);
      hs_d         = in_region(32'(h_nxt), HS_START, HS_END);
      vb_d         = in_region(32'(v_nxt), VB_START, VB_END);
      vs_d         = in_region(32'(v_nxt), VS_START, VS_END);
      line_start_d = v_adv;
      frame_d      = frame_q ^ (vb_d & ~vb_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdump_q      <= '0;
      vdump_q      <= '0;
      hb_q         <= HB_RST;
      vb_q         <= VB_RST;
      hs_q         <= HS_RST;
      vs_q         <= VS_RST;
      frame_q      <= 1'b0;
      line_start_q <= 1'b0;
    end else begin
      hdump_q      <= hdump_d;
      vdump_q      <= vdump_d;
      hb_q         <= hb_d;
      vb_q         <= vb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      frame_q      <= frame_d;
      line_start_q <= line_start_d;
    end
  end

  assign hdump      = hdump_q;
  assign vdump      = vdump_q;
  assign HB         = hb_q;
  assign VB         = vb_q;
  assign HS         = hs_q;
  assign VS         = vs_q;
  assign frame      = frame_q;
  assign line_start = line_start_q;

endmodule

// File: doc/jtframe_vidtimer.md
Name: jtframe_vidtimer

Overview:
Programmable raster timing generator for the jtframe video path. It produces pixel/line counters and the HB, VB, HS and VS strobes that feed the credits/OSD overlay stage and the game's own video logic. It advances only on pixel clock-enable. All outputs are registered and mutually aligned.

Parameters:
HCNT_W, 9, width of hdump
VCNT_W, 9, width of vdump
H_TOTAL, 384, pixels per line; hdump runs 0..H_TOTAL-1
HB_START, 288, first hdump value with HB high
HB_END, 32, first hdump value with HB low again
HS_START, 304, first hdump value with HS high
HS_END, 336, first hdump value with HS low again
V_ADV, 288, hdump value at which vdump advances
V_TOTAL, 264, lines per frame; vdump runs 0..V_TOTAL-1
VB_START, 224, first vdump value with VB high
VB_END, 16, first vdump value with VB low again
VS_START, 240, first vdump value with VS high
VS_END, 244, first vdump value with VS low again

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
pxl_cen  in  1  pixel clock enable
hdump  out  HCNT_W  horizontal pixel counter
vdump  out  VCNT_W  line counter
HB  out  1  horizontal blank, active high
VB  out  1  vertical blank, active high
HS  out  1  horizontal sync, active high
VS  out  1  vertical sync, active high
frame  out  1  toggles once per frame
line_start  out  1  one-clk pulse when hdump becomes V_ADV

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active high. All state updates on posedge clk.
- Reset on any clk edge with rst=1, regardless of pxl_cen: hdump=0, vdump=0, frame=0, line_start=0. HB/VB/HS/VS take the region decode of count 0. With defaults: HB=1, VB=1, HS=0, VS=0.
- Update only when pxl_cen=1. With pxl_cen=0 all outputs hold, and line_start is forced to 0.
- Horizontal count: hdump <= (hdump==H_TOTAL-1) ? 0 : hdump+1.
- Vertical count: on the cen where hdump's next value equals V_ADV, vdump <= (vdump==V_TOTAL-1) ? 0 : vdump+1. line_start pulses high for that one clk.
- Region decode for signal X with START/END, applied to the next counter value so X is aligned with hdump/vdump on the same cycle:
  - START<END: X=1 for START<=n<END.
  - START>END: wrapped region; X=1 for n>=START or n<END.
  - START==END: X is never asserted.
- HB and HS decode the next hdump value. VB and VS decode the next vdump value.
- frame toggles on the cen where VB goes 0->1.
- Counters never exceed TOTAL-1. Elaboration must $error if H_TOTAL>2**HCNT_W, V_TOTAL>2**VCNT_W, or any START/END/V_ADV is >= its TOTAL.
- pxl_cen held at 1 continuously is legal; timing then runs at clk rate.
- Reset mid-line or mid-frame: the next cycle restarts from the reset values. There is no partial-line carry-over.
- Within one cycle, a counter wrap and a region edge may coincide (e.g. END=0). The decode of the new value decides; no glitch is allowed.

Test Plan:
1. Defaults, pxl_cen toggling every clk, rst released. Required: after reset, hdump counts 0..383 and wraps, giving a 768-clk line. HB rises on the cen where hdump=288 and falls where hdump=32. HS is high for hdump 304..335.
2. Defaults, run 2 frames. Required: vdump increments only when hdump becomes 288, and wraps 263->0. VB is high for vdump 224..263 and 0..15. VS is high for vdump 240..243. frame toggles every 384*264=101376 cens. line_start pulses exactly 264 times per frame.
3. Assert rst for one clk at hdump=150, vdump=100. Required: the next cycle shows hdump=0, vdump=0, HB=1, VB=1, HS=0, VS=0, frame=0, and counting resumes from there.
4. Hold pxl_cen=0 for 50 clks mid-line. Required: all counters and strobes stay frozen, and line_start stays 0.
5. Non-wrapping params HB_START=10, HB_END=20, with START==END for HS (HS_START=HS_END=5). Required: HB is high only for hdump 10..19, and HS stays 0 for a full frame.
6. pxl_cen tied to 1 with H_TOTAL=8, V_TOTAL=4, V_ADV=0. Required: vdump advances every 8 clks, exactly when hdump wraps to 0, and frame toggles every 32 clks.
